// File: rtl/credit_rr_arbiter.sv
// -----------------------------------------------------------------------------
// credit_rr_arbiter
//
// Round-robin arbiter that hands out grants from a shared pool of downstream
// credits. Each grant consumes one credit charged to the winning requester;
// the downstream returns credits one at a time, tagged with the owning
// requester. Each requester may hold at most MaxPerReq credits.
//
// Handshakes: a transfer on requester i happens in a cycle where
// req_valid_i[i] && req_ready_o[i]; a grant is consumed downstream in a cycle
// where gnt_valid_o && gnt_ready_i. Once gnt_valid_o is asserted, it and
// gnt_idx_o hold until gnt_ready_i is seen.
//
// Ports
//   clk_i              clock, rising edge
//   rst_i              synchronous active-high reset
//   flush_i            soft re-init, same effect as rst_i
//   req_valid_i        per-requester request
//   req_ready_o        per-requester accept (one-hot or zero)
//   gnt_valid_o        registered grant valid
//   gnt_idx_o          index of granted requester
//   gnt_ready_i        downstream accepts the grant
//   credit_give_i      downstream returns one credit
//   credit_give_idx_i  requester owning the returned credit
//   credits_o          free credits in the pool
//   outstanding_o      per-requester outstanding counts, i at [i*CW +: CW]
//   err_o              sticky flag for an illegal credit return
// -----------------------------------------------------------------------------
module credit_rr_arbiter #(
   parameter int NumReq     = 4,
   parameter int NumCredits = 8,
   parameter int MaxPerReq  = 4,
   localparam int IdxW      = (NumReq > 1) ? $clog2(NumReq) : 1,
   localparam int CW        = $clog2(NumCredits + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic [NumReq-1:0]    req_valid_i,
   output logic [NumReq-1:0]    req_ready_o,
   output logic                 gnt_valid_o,
   output logic [IdxW-1:0]      gnt_idx_o,
   input  logic                 gnt_ready_i,
   input  logic                 credit_give_i,
   input  logic [IdxW-1:0]      credit_give_idx_i,
   output logic [CW-1:0]        credits_o,
   output logic [NumReq*CW-1:0] outstanding_o,
   output logic                 err_o
);

   localparam logic [CW-1:0] PoolMax = CW'(NumCredits);
   localparam logic [CW-1:0] CapMax  = CW'(MaxPerReq);

   logic [CW-1:0]              pool_q, pool_d;
   logic [NumReq-1:0][CW-1:0]  out_q, out_d;
   logic [IdxW-1:0]            rr_q, rr_d;
   logic                       gnt_valid_q, gnt_valid_d;
   logic [IdxW-1:0]            gnt_idx_q, gnt_idx_d;
   logic                       err_q, err_d;

   logic                       clr;
   logic                       slot_free;
   logic [NumReq-1:0]          elig;
   logic                       found;
   logic [IdxW-1:0]            winner;
   logic                       take;
   logic [NumReq-1:0]          give_hot;
   logic                       give_has_out;
   logic                       give_ok;

   assign clr       = rst_i | flush_i;
   assign slot_free = ~gnt_valid_q | gnt_ready_i;

   // Eligibility depends on the request, the shared pool and the own cap.
   always_comb begin
      for (int i = 0; i < NumReq; i++) begin
         elig[i] = req_valid_i[i] && (pool_q != '0) && (out_q[i] < CapMax);
      end
   end

   // First eligible index at or above rr_q, wrapping around.
   always_comb begin : pick
      int cand;
      cand   = 0;
      found  = 1'b0;
      winner = '0;
      for (int k = 0; k < NumReq; k++) begin
         cand = (int'(rr_q) + k) % NumReq;
         if (!found && elig[cand]) begin
            found  = 1'b1;
            winner = IdxW'(cand);
         end
      end
   end

   assign take = found & slot_free & ~clr;

   always_comb begin
      req_ready_o = '0;
      if (take) begin
         req_ready_o[winner] = 1'b1;
      end
   end

   // Decode the returned-credit index; an index beyond NumReq matches no bit,
   // which makes the return illegal.
   always_comb begin
      give_has_out = 1'b0;
      for (int i = 0; i < NumReq; i++) begin
         give_hot[i] = (credit_give_idx_i == IdxW'(i));
         if (give_hot[i] && (out_q[i] != '0)) begin
            give_has_out = 1'b1;
         end
      end
   end

   assign give_ok = credit_give_i & give_has_out & (pool_q != PoolMax) & ~clr;

   always_comb begin
      pool_d      = pool_q;
      out_d       = out_q;
      rr_d        = rr_q;
      gnt_valid_d = gnt_valid_q;
      gnt_idx_d   = gnt_idx_q;
      err_d       = err_q | (credit_give_i & ~give_ok);

      // Take and give on the same cycle cancel in the pool.
      case ({take, give_ok})
         2'b10:   pool_d = pool_q - CW'(1);
         2'b01:   pool_d = pool_q + CW'(1);
         default: pool_d = pool_q;
      endcase

      // Per-requester counters move independently; +1 and -1 on the same
      // index leave it unchanged.
      for (int i = 0; i < NumReq; i++) begin
         if (take && (winner == IdxW'(i)) && !(give_ok && give_hot[i])) begin
            out_d[i] = out_q[i] + CW'(1);
         end else if (give_ok && give_hot[i] && !(take && (winner == IdxW'(i)))) begin
            out_d[i] = out_q[i] - CW'(1);
         end
      end

      if (take) begin
         gnt_valid_d = 1'b1;
         gnt_idx_d   = winner;
         rr_d        = (winner == IdxW'(NumReq - 1)) ? '0 : winner + IdxW'(1);
      end else if (gnt_ready_i) begin
         gnt_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr) begin
         pool_q      <= PoolMax;
         out_q       <= '0;
         rr_q        <= '0;
         gnt_valid_q <= 1'b0;
         gnt_idx_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         pool_q      <= pool_d;
         out_q       <= out_d;
         rr_q        <= rr_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_idx_q   <= gnt_idx_d;
         err_q       <= err_d;
      end
   end

   assign gnt_valid_o   = gnt_valid_q;
   assign gnt_idx_o     = gnt_idx_q;
   assign credits_o     = pool_q;
   assign outstanding_o = out_q;
   assign err_o         = err_q;

endmodule
